// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and frame constants for the PS/2 keyboard receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: MCU-side scan-code pop handshake and sticky error flags
interface ps2_keyboard_rx_if;
  import ps2_pkg::*;
  logic ERR_CLR;
  logic ACK;
  logic [DATA_BITS-1:0] SCAN_CODE;
  logic VALID;
  logic FRAME_ERR;
  logic OVERFLOW;
  modport master (output ERR_CLR, ACK, input SCAN_CODE, VALID, FRAME_ERR, OVERFLOW);
  modport slave (input ERR_CLR, ACK, output SCAN_CODE, VALID, FRAME_ERR, OVERFLOW);
endinterface

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: show-ahead synchronous byte FIFO, head reads as zero when empty
module ps2_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? 8'h00 : mem[rd];
  // pointers wrap naturally at DEPTH; a pop frees a slot for a same-cycle push when full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; occupancy is tracked by cnt
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host receiver with filtering, deframing, scan-code FIFO and error flags
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input logic CLK,
  input logic RST,
  input logic PS2CLK,
  input logic PS2DATA,
  ps2_keyboard_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync [2];
  logic [FW-1:0] fcnt [2];
  logic [1:0] filt, raw;
  logic filt_clk_q, fall, bit_in;
  ps2_state_t state;
  logic [2:0] bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic parity_ok;
  logic [TW-1:0] tcnt;
  logic timeout, push, pop, full, empty, frame_err_set, overflow_set;
  assign raw = {PS2DATA, PS2CLK};
  assign fall = filt_clk_q & ~filt[0];
  assign bit_in = filt[1];
  assign timeout = state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign push = fall && state == STOP && bit_in && parity_ok;
  assign pop = bus.ACK & ~empty;
  assign frame_err_set = timeout | (fall && state == STOP && !(bit_in && parity_ok));
  assign overflow_set = push & full & ~pop;
  assign bus.VALID = ~empty;
  // synchronise both pins, then require FILTER_LEN consecutive disagreeing samples before the filtered line flips
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= '1;
        fcnt[i] <= '0;
      end
      filt <= '1;
      filt_clk_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
        if (sync[i][SYNC_STAGES-1] != filt[i]) begin
          if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
            filt[i] <= ~filt[i];
            fcnt[i] <= '0;
          end else fcnt[i] <= fcnt[i] + FW'(1);
        end else fcnt[i] <= '0;
      end
      filt_clk_q <= filt[0];
    end
  // frame deframer advancing on filtered clock falls; a stalled partial frame is abandoned on timeout
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      bitcnt <= '0;
      shreg <= '0;
      parity_ok <= 1'b0;
      tcnt <= '0;
    end else begin
      tcnt <= (state == IDLE || fall || timeout) ? '0 : tcnt + TW'(1);
      if (timeout) begin
        state <= IDLE;
        bitcnt <= '0;
        shreg <= '0;
      end else if (fall) begin
        case (state)
          IDLE: if (!bit_in) begin
            state <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            shreg <= {bit_in, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'(DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= ^{shreg, bit_in};
            state <= STOP;
          end
          STOP: state <= IDLE;
        endcase
      end
    end
  // sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      bus.FRAME_ERR <= 1'b0;
      bus.OVERFLOW <= 1'b0;
    end else begin
      bus.FRAME_ERR <= frame_err_set | (bus.FRAME_ERR & ~bus.ERR_CLR);
      bus.OVERFLOW <= overflow_set | (bus.OVERFLOW & ~bus.ERR_CLR);
    end
  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .din(shreg),
    .full(full),
    .pop(pop),
    .dout(bus.SCAN_CODE),
    .empty(empty)
  );
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed frame vectors plus overflow, timeout, glitch and reset sequences
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic PS2CLK = 1'b1;
  logic PS2DATA = 1'b1;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [7:0] d;
    logic bad_par;
    logic bad_stop;
    logic exp_valid;
    logic [7:0] exp_code;
    logic exp_ferr;
  } vec_t;
  vec_t vecs [7];
  logic [7:0] codes [6];
  logic [FRAME_BITS-1:0] f;
  ps2_keyboard_rx_if bus();
  ps2_keyboard_rx #(.TIMEOUT_CYCLES(2000)) dut (
    .CLK(CLK),
    .RST(RST),
    .PS2CLK(PS2CLK),
    .PS2DATA(PS2DATA),
    .bus(bus.slave)
  );
  always #5 CLK = ~CLK;
  function automatic logic [FRAME_BITS-1:0] mk(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic send_bits(input logic [FRAME_BITS-1:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      #100 PS2DATA = fr[i];
      #100 PS2CLK = 1'b0;
      #200 PS2CLK = 1'b1;
    end
  endtask
  task automatic send(input logic [FRAME_BITS-1:0] fr);
    send_bits(fr, 0, FRAME_BITS - 1);
    #100 PS2DATA = 1'b1;
    #300;
    @(negedge CLK);
  endtask
  task automatic ack();
    @(negedge CLK) bus.ACK = 1'b1;
    @(negedge CLK) bus.ACK = 1'b0;
  endtask
  task automatic clr();
    @(negedge CLK) bus.ERR_CLR = 1'b1;
    @(negedge CLK) bus.ERR_CLR = 1'b0;
  endtask
  task automatic glitch();
    @(negedge CLK) PS2CLK = 1'b0;
    @(negedge CLK) PS2CLK = 1'b1;
  endtask
  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[6] = '{8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    codes = '{8'hF0, 8'h1C, 8'h5A, 8'h12, 8'h29, 8'h33};
    bus.ACK = 1'b0;
    bus.ERR_CLR = 1'b0;
    #23;
    chk("rst_valid", 8'(bus.VALID), 8'h00);
    chk("rst_code", bus.SCAN_CODE, 8'h00);
    chk("rst_ferr", 8'(bus.FRAME_ERR), 8'h00);
    chk("rst_ovf", 8'(bus.OVERFLOW), 8'h00);
    @(negedge CLK) RST = 1'b0;
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 7; i++) begin
      send(mk(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop));
      chk($sformatf("vec%0d_valid", i), 8'(bus.VALID), 8'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_code", i), bus.SCAN_CODE, vecs[i].exp_code);
      chk($sformatf("vec%0d_ferr", i), 8'(bus.FRAME_ERR), 8'(vecs[i].exp_ferr));
      if (vecs[i].exp_valid) begin
        ack();
        chk($sformatf("vec%0d_ack_valid", i), 8'(bus.VALID), 8'h00);
      end
      clr();
      chk($sformatf("vec%0d_clr_ferr", i), 8'(bus.FRAME_ERR), 8'h00);
    end
    for (int k = 0; k < 6; k++) begin
      send(mk(codes[k], 1'b0, 1'b0));
      if (k == 3) chk("full_no_ovf", 8'(bus.OVERFLOW), 8'h00);
      if (k == 4) chk("ovf_after_5th", 8'(bus.OVERFLOW), 8'h01);
    end
    chk("ovf_valid", 8'(bus.VALID), 8'h01);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_pop%0d", k), bus.SCAN_CODE, codes[k]);
      ack();
    end
    chk("ovf_drained", 8'(bus.VALID), 8'h00);
    chk("ovf_sticky", 8'(bus.OVERFLOW), 8'h01);
    clr();
    chk("ovf_clr", 8'(bus.OVERFLOW), 8'h00);
    send_bits(mk(8'h77, 1'b0, 1'b0), 0, 5);
    #100 PS2DATA = 1'b1;
    repeat (1000) @(negedge CLK);
    chk("to_early", 8'(bus.FRAME_ERR), 8'h00);
    repeat (1100) @(negedge CLK);
    chk("to_ferr", 8'(bus.FRAME_ERR), 8'h01);
    chk("to_valid", 8'(bus.VALID), 8'h00);
    clr();
    send(mk(8'h5A, 1'b0, 1'b0));
    chk("to_next_valid", 8'(bus.VALID), 8'h01);
    chk("to_next_code", bus.SCAN_CODE, 8'h5A);
    chk("to_next_ferr", 8'(bus.FRAME_ERR), 8'h00);
    ack();
    repeat (10) @(negedge CLK);
    glitch();
    repeat (20) @(negedge CLK);
    chk("gl_idle_valid", 8'(bus.VALID), 8'h00);
    chk("gl_idle_ferr", 8'(bus.FRAME_ERR), 8'h00);
    f = mk(8'h1C, 1'b0, 1'b0);
    send_bits(f, 0, 3);
    #100;
    glitch();
    send_bits(f, 4, FRAME_BITS - 1);
    #100 PS2DATA = 1'b1;
    #300;
    @(negedge CLK);
    chk("gl_mid_valid", 8'(bus.VALID), 8'h01);
    chk("gl_mid_code", bus.SCAN_CODE, 8'h1C);
    chk("gl_mid_ferr", 8'(bus.FRAME_ERR), 8'h00);
    ack();
    send(mk(8'h1C, 1'b1, 1'b0));
    send(mk(8'h29, 1'b0, 1'b0));
    send(mk(8'h33, 1'b0, 1'b0));
    chk("pre_rst_valid", 8'(bus.VALID), 8'h01);
    chk("pre_rst_ferr", 8'(bus.FRAME_ERR), 8'h01);
    send_bits(mk(8'h5A, 1'b0, 1'b0), 0, 4);
    #3 RST = 1'b1;
    #1;
    chk("mid_rst_valid", 8'(bus.VALID), 8'h00);
    chk("mid_rst_code", bus.SCAN_CODE, 8'h00);
    chk("mid_rst_ferr", 8'(bus.FRAME_ERR), 8'h00);
    chk("mid_rst_ovf", 8'(bus.OVERFLOW), 8'h00);
    PS2DATA = 1'b1;
    #30;
    @(negedge CLK) RST = 1'b0;
    repeat (20) @(negedge CLK);
    send(mk(8'h33, 1'b0, 1'b0));
    chk("post_rst_valid", 8'(bus.VALID), 8'h01);
    chk("post_rst_code", bus.SCAN_CODE, 8'h33);
    chk("post_rst_ferr", 8'(bus.FRAME_ERR), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
